mode_runtime_tracker: RTL and testbench
=======================================

// Module: mode_runtime_tracker
// PURPOSE
//  Generalised per-mode run-time accounting for the hood controller; tracks NUM_MODES modes with one block.
//  Keeps, per mode, current run time (seconds since last entry) and accumulated total seconds.
//  Adds pause/hold, total clear, saturation flags, a mode-change pulse and a per-second tick.
//  Sits beside the mode controller; feeds the display mux and maintenance (filter-hours) logic.
// PARAMETERS
//  NUM_MODES      4            tracked modes; mode codes 1..NUM_MODES, code 0 = idle/off
//  MODE_WIDTH     3            width of mode code; must hold NUM_MODES
//  TIME_WIDTH     16           width of every seconds counter
//  TICKS_PER_SEC  100_000_000  clk cycles per second (>=2)
//  PRE_WIDTH      27           prescaler width; must hold TICKS_PER_SEC-1
// PORTS
//  clk            in   1                      system clock
//  rstn           in   1                      asynchronous, active-low reset
//  current_mode   in   MODE_WIDTH             live mode code from mode controller
//  pause          in   1                      1 = hold prescaler and all counters
//  clr_total      in   1                      1-cycle pulse: clear all totals and sat flags
//  sel_mode       in   MODE_WIDTH             read select for sel_total
//  current_running_time out TIME_WIDTH        seconds in active tracked mode, else 0
//  sel_total      out  TIME_WIDTH             total of mode sel_mode (0 if sel_mode untracked)
//  total_flat     out  NUM_MODES*TIME_WIDTH   all totals; mode m at [(m-1)*TIME_WIDTH +: TIME_WIDTH]
//  sat_flags      out  NUM_MODES              sticky: total of mode m hit all-ones (bit m-1)
//  sec_tick       out  1                      1-cycle pulse on each counted second
//  mode_change    out  1                      1-cycle pulse when current_mode differs from last cycle
// BEHAVIOUR
//  - Reset: all outputs, totals, prescaler, sat flags, registered mode (mode_q) = 0.
//  - Tracked = current_mode in 1..NUM_MODES; 0 and codes > NUM_MODES are untracked.
//  - Change cycle (current_mode != mode_q): mode_q <= current_mode; prescaler <= 0; current <= 0;
//    mode_change registered high next cycle for 1 cycle; no second counted this cycle, even if pause=0.
//  - Counting (tracked, no change, pause=0): prescaler increments; at TICKS_PER_SEC-1 it wraps to 0,
//    sec_tick pulses (registered, next cycle), current +1 and total[mode] +1 (visible next cycle).
//  - Latency: mode steady from change cycle C -> prescaler==TICKS_PER_SEC-1 at C+TICKS_PER_SEC,
//    current=1 and sec_tick=1 from C+TICKS_PER_SEC+1.
//  - pause=1: prescaler, current and totals hold (not cleared); a mode change during pause still
//    clears current and prescaler and pulses mode_change.
//  - Untracked mode: prescaler and current forced to 0; totals hold.
//  - Saturation: current and totals stop at all-ones (no wrap); on a total reaching all-ones, set
//    its sat flag; flags stay set until clr_total or reset.
//  - clr_total with same-cycle second tick: clear wins for totals/flags; current still increments.
//  - clr_total does not affect current, prescaler or mode_q.
//  - sel_total: combinational mux of total registers by sel_mode.
//  - Reset mid-count: everything back to 0 immediately (async); restart counts from next change.
// STRUCTURE
//  - Shared parameters header/package: MODE_IDLE=0, mode code constants, default TICKS_PER_SEC.
//  - Sub-module mode_sec_prescaler: PRE_WIDTH counter with en, sync clr, wrap at TICKS_PER_SEC-1,
//    tick output; one instance.
//  - Totals: generate loop of NUM_MODES saturating TIME_WIDTH registers plus sat flags.
// TESTING (TICKS_PER_SEC=4, TIME_WIDTH=4, NUM_MODES=4)
//  - Reset then mode 0->1 at C -> mode_change at C+1; sec_tick/current=1 at C+5, current=2 at C+9.
//  - Mode 1 for 3 s, switch to 2 for 2 s -> current=0 on switch; total1=3, total2=2, sel_total follows sel.
//  - pause=1 for 10 cycles mid-second -> no tick; counting resumes from held prescaler value.
//  - Mode 3 for 20 s -> current and total3 stop at 15, sat_flags[2]=1; clr_total -> total3=0, flag 0.
//  - clr_total on same cycle as tick -> totals 0 next cycle, current incremented.
//  - Mode 7 (untracked) and mode 0 -> current=0, no sec_tick; async rstn low mid-count -> all outputs 0.

Source files
------------

// File: rtl/mode_runtime_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module : mode_runtime_tracker_pkg
// Brief  : Shared mode codes and timing defaults for the run-time tracker.
// Rev    : 1.0  initial release
// ============================================================================
package mode_runtime_tracker_pkg;

    localparam int MODE_IDLE = 0;
    localparam int MODE_1    = 1;
    localparam int MODE_2    = 2;
    localparam int MODE_3    = 3;
    localparam int MODE_4    = 4;

    localparam int DEFAULT_TICKS_PER_SEC = 100_000_000;

    // Codes above the configured mode count behave like idle.
    function automatic logic is_tracked(input int unsigned code, input int unsigned num_modes);
        return (code != MODE_IDLE) && (code <= num_modes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_runtime_tracker_sec.sv
`default_nettype none
// ============================================================================
// Module : mode_sec_prescaler
// Brief  : Clock-cycle prescaler that emits one tick per counted second.
// Rev    : 1.0  initial release
// ============================================================================
module mode_sec_prescaler #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int PRE_WIDTH     = 27
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [PRE_WIDTH-1:0] C_WRAP = PRE_WIDTH'(TICKS_PER_SEC - 1);

    logic [PRE_WIDTH-1:0] r_count;

    assign o_tick = i_en && !i_clr && (r_count == C_WRAP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + PRE_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mode_runtime_tracker.sv
`default_nettype none
// ============================================================================
// Module : mode_runtime_tracker
// Brief  : Per-mode current and accumulated run-time seconds with saturation.
// Rev    : 1.0  initial release
// ============================================================================
module mode_runtime_tracker
    import mode_runtime_tracker_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int MODE_WIDTH    = 3,
    parameter int TIME_WIDTH    = 16,
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int PRE_WIDTH     = 27
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [MODE_WIDTH-1:0]           current_mode,
    input  logic                            pause,
    input  logic                            clr_total,
    input  logic [MODE_WIDTH-1:0]           sel_mode,
    output logic [TIME_WIDTH-1:0]           current_running_time,
    output logic [TIME_WIDTH-1:0]           sel_total,
    output logic [NUM_MODES*TIME_WIDTH-1:0] total_flat,
    output logic [NUM_MODES-1:0]            sat_flags,
    output logic                            sec_tick,
    output logic                            mode_change
);

    localparam logic [TIME_WIDTH-1:0] C_TIME_MAX = '1;

    logic [MODE_WIDTH-1:0] r_mode_q;
    logic [TIME_WIDTH-1:0] r_current;
    logic                  r_sec_tick;
    logic                  r_mode_change;
    logic                  w_change;
    logic                  w_tracked;
    logic                  w_tick;
    logic [TIME_WIDTH-1:0] w_total [NUM_MODES];

    assign w_change  = (current_mode != r_mode_q);
    assign w_tracked = is_tracked(32'(current_mode), NUM_MODES);

    // A change cycle restarts the second; untracked modes keep the prescaler parked at 0.
    mode_sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRE_WIDTH     (PRE_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (w_tracked && !w_change && !pause),
        .i_clr  (w_change || !w_tracked),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode_q      <= '0;
            r_current     <= '0;
            r_sec_tick    <= 1'b0;
            r_mode_change <= 1'b0;
        end else begin
            r_mode_q      <= current_mode;
            r_mode_change <= w_change;
            r_sec_tick    <= w_tick;
            if (w_change || !w_tracked) begin
                r_current <= '0;
            end else if (w_tick && (r_current != C_TIME_MAX)) begin
                r_current <= r_current + TIME_WIDTH'(1);
            end
        end
    end

    genvar m;
    generate
        for (m = 0; m < NUM_MODES; m++) begin : g_total
            logic [TIME_WIDTH-1:0] r_total;
            logic                  r_sat;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_total <= '0;
                    r_sat   <= 1'b0;
                end else if (clr_total) begin
                    r_total <= '0;
                    r_sat   <= 1'b0;
                end else if (w_tick && (current_mode == MODE_WIDTH'(m + 1))
                             && (r_total != C_TIME_MAX)) begin
                    r_total <= r_total + TIME_WIDTH'(1);
                    if (r_total == C_TIME_MAX - TIME_WIDTH'(1)) begin
                        r_sat <= 1'b1;
                    end
                end
            end

            assign w_total[m]                               = r_total;
            assign total_flat[m*TIME_WIDTH +: TIME_WIDTH]   = r_total;
            assign sat_flags[m]                             = r_sat;
        end
    endgenerate

    always_comb begin
        sel_total = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (sel_mode == MODE_WIDTH'(i + 1)) begin
                sel_total = w_total[i];
            end
        end
    end

    assign current_running_time = r_current;
    assign sec_tick             = r_sec_tick;
    assign mode_change          = r_mode_change;

endmodule
`default_nettype wire

// File: tb/tb_mode_runtime_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_mode_runtime_tracker
// Brief  : Self-checking bench comparing the tracker against a seconds model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mode_runtime_tracker;

    localparam int NM   = 4;
    localparam int MW   = 3;
    localparam int TW   = 4;
    localparam int TPS  = 4;
    localparam int PW   = 3;
    localparam int TMAX = (1 << TW) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [MW-1:0]     current_mode = '0;
    logic              pause = 1'b0;
    logic              clr_total = 1'b0;
    logic [MW-1:0]     sel_mode = '0;
    logic [TW-1:0]     current_running_time;
    logic [TW-1:0]     sel_total;
    logic [NM*TW-1:0]  total_flat;
    logic [NM-1:0]     sat_flags;
    logic              sec_tick;
    logic              mode_change;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: counted clock cycles since mode entry, seconds per mode.
    int m_mode_q;
    int m_cnt;
    int m_tot [NM];
    bit m_sat [NM];
    bit m_tick;
    bit m_chg;

    mode_runtime_tracker #(
        .NUM_MODES     (NM),
        .MODE_WIDTH    (MW),
        .TIME_WIDTH    (TW),
        .TICKS_PER_SEC (TPS),
        .PRE_WIDTH     (PW)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .current_mode         (current_mode),
        .pause                (pause),
        .clr_total            (clr_total),
        .sel_mode             (sel_mode),
        .current_running_time (current_running_time),
        .sel_total            (sel_total),
        .total_flat           (total_flat),
        .sat_flags            (sat_flags),
        .sec_tick             (sec_tick),
        .mode_change          (mode_change)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode_q = 0;
        m_cnt    = 0;
        m_tick   = 0;
        m_chg    = 0;
        for (int i = 0; i < NM; i++) begin
            m_tot[i] = 0;
            m_sat[i] = 0;
        end
    endtask

    function automatic int model_current();
        int s;
        s = m_cnt / TPS;
        return (s > TMAX) ? TMAX : s;
    endfunction

    task automatic model_update();
        int  md;
        bit  trk;
        md     = int'(current_mode);
        trk    = (md >= 1) && (md <= NM);
        m_tick = 0;
        m_chg  = (md != m_mode_q);
        if (m_chg) begin
            m_mode_q = md;
            m_cnt    = 0;
        end else if (!trk) begin
            m_cnt = 0;
        end else if (!pause) begin
            m_cnt++;
            m_tick = ((m_cnt % TPS) == 0);
        end
        if (clr_total) begin
            for (int i = 0; i < NM; i++) begin
                m_tot[i] = 0;
                m_sat[i] = 0;
            end
        end else if (m_tick) begin
            if (m_tot[md-1] < TMAX) m_tot[md-1]++;
            if (m_tot[md-1] == TMAX) m_sat[md-1] = 1;
        end
    endtask

    task automatic compare_all();
        int sel;
        int exp_sel;
        check_eq("current", 32'(current_running_time), model_current());
        check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
        check_eq("mode_change", 32'(mode_change), 32'(m_chg));
        for (int i = 0; i < NM; i++) begin
            check_eq($sformatf("total%0d", i + 1), 32'(total_flat[i*TW +: TW]), m_tot[i]);
            check_eq($sformatf("sat%0d", i + 1), 32'(sat_flags[i]), 32'(m_sat[i]));
        end
        sel     = int'(sel_mode);
        exp_sel = (sel >= 1 && sel <= NM) ? m_tot[sel-1] : 0;
        check_eq("sel_total", 32'(sel_total), exp_sel);
    endtask

    task automatic step(input int md, input bit ps, input bit cl);
        current_mode = MW'(md);
        pause        = ps;
        clr_total    = cl;
        sel_mode     = MW'($urandom_range(0, 7));
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cur"}, 32'(current_running_time), 0);
        check_eq({tag, "_flat"}, 32'(total_flat), 0);
        check_eq({tag, "_sat"}, 32'(sat_flags), 0);
        check_eq({tag, "_tick"}, 32'(sec_tick), 0);
        check_eq({tag, "_chg"}, 32'(mode_change), 0);
    endtask

    initial begin
        int md;
        int guard;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        step(0, 0, 0);

        // Entry latency: change cycle then first second after TPS counted cycles.
        step(1, 0, 0);
        check_eq("lat_chg", 32'(mode_change), 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check_eq("lat_sec1", 32'(current_running_time), 1);
        check_eq("lat_tick1", 32'(sec_tick), 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check_eq("lat_sec2", 32'(current_running_time), 2);

        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(2, 0, 0);
        check_eq("switch_cur", 32'(current_running_time), 0);
        for (int i = 0; i < 2 * TPS; i++) step(2, 0, 0);
        check_eq("total1", 32'(total_flat[0 +: TW]), 3);
        check_eq("total2", 32'(total_flat[TW +: TW]), 2);

        // Hold mid-second, then resume.
        step(2, 0, 0);
        step(2, 0, 0);
        for (int i = 0; i < 10; i++) step(2, 1, 0);
        for (int i = 0; i < 6; i++) step(2, 0, 0);

        for (int i = 0; i < 20 * TPS + 1; i++) step(3, 0, 0);
        check_eq("sat_cur", 32'(current_running_time), TMAX);
        check_eq("sat_total3", 32'(total_flat[2*TW +: TW]), TMAX);
        check_eq("sat_flag3", 32'(sat_flags[2]), 1);
        step(3, 0, 1);
        check_eq("clr_total3", 32'(total_flat[2*TW +: TW]), 0);
        check_eq("clr_flag3", 32'(sat_flags[2]), 0);

        // Clear landing on the same cycle as a counted second.
        step(1, 0, 0);
        guard = 0;
        while (((m_cnt % TPS) != TPS - 1) && guard < 20) begin
            step(1, 0, 0);
            guard++;
        end
        check_eq("clr_tick_align", 32'(guard < 20), 1);
        step(1, 0, 1);
        check_eq("clr_tick_tick", 32'(sec_tick), 1);
        check_eq("clr_tick_total1", 32'(total_flat[0 +: TW]), 0);

        for (int i = 0; i < 12; i++) step(7, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0);

        // Randomised traffic.
        md = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) md = $urandom_range(0, 7);
            step(md, ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset in the middle of a count.
        for (int i = 0; i < 2 * TPS + 2; i++) step(2, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #2 rstn = 1'b1;
        for (int i = 0; i < 3 * TPS; i++) step(2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
